// File: rtl/nmea_gll_parser.sv
// $GPGLL sentence parser: frames NMEA bytes from the UART, checks the XOR checksum,
// decodes position/time/status and holds the last good fix on registered outputs.
module nmea_gll_parser #(
    parameter int MAX_LEN = 82,
    parameter int DEG_SAT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  lat_deg,
    output logic [7:0]  lat_min,
    output logic        lat_south,
    output logic [7:0]  lon_deg,
    output logic [7:0]  lon_min,
    output logic        lon_west,
    output logic [23:0] time_bcd,
    output logic        fix_valid,
    output logic        frame_done,
    output logic        cksum_ok,
    output logic        frame_err
);

    // state  | meaning
    // IDLE   | hunting for '$'
    // HDR    | matching "GPGLL"
    // FIELDS | comma-separated payload, checksummed
    // CK_HI  | first checksum hex digit
    // CK_LO  | second checksum hex digit, completes the sentence
    typedef enum logic [2:0] {IDLE, HDR, FIELDS, CK_HI, CK_LO} state_t;

    localparam logic [7:0]  LP_MAX = 8'(MAX_LEN);
    localparam logic [11:0] LP_SAT = 12'(DEG_SAT);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_len, r_cksum;
    logic [2:0]  r_hdr_cnt, r_field_idx, r_fld_cnt, r_int_cnt, r_time_cnt;
    logic        r_dot, r_bad_field, r_status_ok, r_ck_bad;
    logic [7:0]  r_deg_acc;
    logic [3:0]  r_m_tens, r_m_ones, r_rx_hi;
    logic [23:0] r_time_sh;
    logic [7:0]  r_lat_deg_s, r_lat_min_s, r_lon_deg_s, r_lon_min_s;
    logic        r_lat_s_s, r_lon_w_s;

    logic [7:0]  r_lat_deg, r_lat_min, r_lon_deg, r_lon_min;
    logic        r_lat_south, r_lon_west, r_fix_valid, r_frame_done, r_cksum_ok, r_frame_err;
    logic [23:0] r_time_bcd;

    logic        w_is_dollar, w_is_star, w_is_comma, w_is_digit, w_is_dot;
    logic        w_len_abort, w_hdr_bad, w_abort, w_hex_ok, w_ck_match;
    logic [3:0]  w_hex_nib;
    logic [7:0]  w_hdr_char, w_min, w_deg_nxt;
    logic [11:0] w_deg_calc;

    assign w_is_dollar = rx_valid && (rx_data == 8'h24);
    assign w_is_star   = (rx_data == 8'h2A);
    assign w_is_comma  = (rx_data == 8'h2C);
    assign w_is_dot    = (rx_data == 8'h2E);
    assign w_is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_min       = {4'b0, r_m_tens} * 8'd10 + {4'b0, r_m_ones};
    assign w_deg_calc  = {4'b0, r_deg_acc} * 12'd10 + {8'b0, r_m_tens};
    assign w_deg_nxt   = (w_deg_calc > LP_SAT) ? LP_SAT[7:0] : w_deg_calc[7:0];
    assign w_abort     = w_len_abort || w_hdr_bad;
    assign w_ck_match  = w_hex_ok && !r_ck_bad && ({r_rx_hi, w_hex_nib} == r_cksum);

    always_comb begin
        w_hex_ok  = 1'b0;
        w_hex_nib = rx_data[3:0];
        if (w_is_digit) begin
            w_hex_ok = 1'b1;
        end else if ((rx_data >= 8'h41) && (rx_data <= 8'h46)) begin
            w_hex_ok  = 1'b1;
            w_hex_nib = rx_data[3:0] + 4'd9;
        end
    end

    always_comb begin
        case (r_hdr_cnt)
            3'd0:    w_hdr_char = 8'h47;
            3'd1:    w_hdr_char = 8'h50;
            3'd2:    w_hdr_char = 8'h47;
            default: w_hdr_char = 8'h4C;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_abort = 1'b0;
        w_hdr_bad   = 1'b0;
        if (rx_valid) begin
            if (w_is_dollar) begin
                w_state_nxt = HDR;
            end else if ((r_state != IDLE) && (r_len >= LP_MAX)) begin
                w_len_abort = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    HDR: begin
                        if (rx_data != w_hdr_char) begin
                            w_hdr_bad   = 1'b1;
                            w_state_nxt = IDLE;
                        end else if (r_hdr_cnt == 3'd4) begin
                            w_state_nxt = FIELDS;
                        end
                    end
                    FIELDS:  if (w_is_star) w_state_nxt = CK_HI;
                    CK_HI:   w_state_nxt = CK_LO;
                    CK_LO:   w_state_nxt = IDLE;
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_len <= '0; r_cksum <= '0; r_hdr_cnt <= '0; r_field_idx <= '0;
            r_fld_cnt <= '0; r_int_cnt <= '0; r_time_cnt <= '0; r_dot <= 1'b0;
            r_bad_field <= 1'b0; r_status_ok <= 1'b0; r_ck_bad <= 1'b0;
            r_deg_acc <= '0; r_m_tens <= '0; r_m_ones <= '0; r_rx_hi <= '0;
            r_time_sh <= '0; r_lat_deg_s <= '0; r_lat_min_s <= '0;
            r_lon_deg_s <= '0; r_lon_min_s <= '0; r_lat_s_s <= 1'b0; r_lon_w_s <= 1'b0;
            r_lat_deg <= '0; r_lat_min <= '0; r_lat_south <= 1'b0;
            r_lon_deg <= '0; r_lon_min <= '0; r_lon_west <= 1'b0;
            r_time_bcd <= '0; r_fix_valid <= 1'b0; r_frame_done <= 1'b0;
            r_cksum_ok <= 1'b0; r_frame_err <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (rx_valid) begin
                if (w_is_dollar) begin
                    r_len <= 8'd1; r_cksum <= '0; r_hdr_cnt <= '0; r_field_idx <= '0;
                    r_fld_cnt <= '0; r_int_cnt <= '0; r_time_cnt <= '0; r_dot <= 1'b0;
                    r_bad_field <= 1'b0; r_status_ok <= 1'b0; r_ck_bad <= 1'b0;
                    r_deg_acc <= '0; r_m_tens <= '0; r_m_ones <= '0; r_time_sh <= '0;
                    r_lat_deg_s <= '0; r_lat_min_s <= '0; r_lon_deg_s <= '0;
                    r_lon_min_s <= '0; r_lat_s_s <= 1'b0; r_lon_w_s <= 1'b0;
                end else if (w_abort) begin
                    r_frame_err <= 1'b1;
                end else begin
                    if (r_state != IDLE) r_len <= r_len + 8'd1;
                    case (r_state)
                        HDR: begin
                            r_cksum   <= r_cksum ^ rx_data;
                            r_hdr_cnt <= r_hdr_cnt + 3'd1;
                        end
                        FIELDS: begin
                            if (!w_is_star) r_cksum <= r_cksum ^ rx_data;
                            if (w_is_comma || w_is_star) begin
                                // field boundary: commit the finished field, then clear per-field state
                                case (r_field_idx)
                                    3'd1: begin r_lat_deg_s <= r_deg_acc; r_lat_min_s <= w_min; end
                                    3'd3: begin r_lon_deg_s <= r_deg_acc; r_lon_min_s <= w_min; end
                                    3'd2, 3'd4: if (r_fld_cnt == 3'd0) r_bad_field <= 1'b1;
                                    3'd5: if (r_time_cnt != 3'd6) r_bad_field <= 1'b1;
                                    default: ;
                                endcase
                                r_fld_cnt <= '0; r_int_cnt <= '0; r_dot <= 1'b0;
                                r_deg_acc <= '0; r_m_tens <= '0; r_m_ones <= '0;
                                if (w_is_comma && (r_field_idx != 3'd7))
                                    r_field_idx <= r_field_idx + 3'd1;
                            end else begin
                                if (r_fld_cnt != 3'd7) r_fld_cnt <= r_fld_cnt + 3'd1;
                                case (r_field_idx)
                                    3'd1, 3'd3: begin
                                        if (w_is_digit) begin
                                            if (!r_dot) begin
                                                if (r_int_cnt == 3'd5) begin
                                                    r_bad_field <= 1'b1;
                                                end else begin
                                                    r_deg_acc <= w_deg_nxt;
                                                    r_m_tens  <= r_m_ones;
                                                    r_m_ones  <= rx_data[3:0];
                                                    r_int_cnt <= r_int_cnt + 3'd1;
                                                end
                                            end
                                        end else if (w_is_dot && !r_dot) begin
                                            r_dot <= 1'b1;
                                        end else begin
                                            r_bad_field <= 1'b1;
                                        end
                                    end
                                    3'd2: begin
                                        if ((r_fld_cnt == 3'd0) && ((rx_data == 8'h4E) || (rx_data == 8'h53)))
                                            r_lat_s_s <= (rx_data == 8'h53);
                                        else
                                            r_bad_field <= 1'b1;
                                    end
                                    3'd4: begin
                                        if ((r_fld_cnt == 3'd0) && ((rx_data == 8'h45) || (rx_data == 8'h57)))
                                            r_lon_w_s <= (rx_data == 8'h57);
                                        else
                                            r_bad_field <= 1'b1;
                                    end
                                    3'd5: begin
                                        if (w_is_digit && !r_dot && (r_time_cnt != 3'd6)) begin
                                            r_time_sh  <= {r_time_sh[19:0], rx_data[3:0]};
                                            r_time_cnt <= r_time_cnt + 3'd1;
                                        end else if (w_is_dot) begin
                                            r_dot <= 1'b1;
                                        end
                                    end
                                    3'd6: r_status_ok <= (r_fld_cnt == 3'd0) && (rx_data == 8'h41);
                                    default: ;
                                endcase
                            end
                        end
                        CK_HI: begin
                            r_rx_hi <= w_hex_nib;
                            if (!w_hex_ok) r_ck_bad <= 1'b1;
                        end
                        CK_LO: begin
                            r_frame_done <= 1'b1;
                            r_cksum_ok   <= w_ck_match;
                            if (w_ck_match && r_status_ok && !r_bad_field && (r_field_idx >= 3'd6)) begin
                                r_lat_deg   <= r_lat_deg_s;
                                r_lat_min   <= r_lat_min_s;
                                r_lat_south <= r_lat_s_s;
                                r_lon_deg   <= r_lon_deg_s;
                                r_lon_min   <= r_lon_min_s;
                                r_lon_west  <= r_lon_w_s;
                                r_time_bcd  <= r_time_sh;
                                r_fix_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign lat_deg    = r_lat_deg;
    assign lat_min    = r_lat_min;
    assign lat_south  = r_lat_south;
    assign lon_deg    = r_lon_deg;
    assign lon_min    = r_lon_min;
    assign lon_west   = r_lon_west;
    assign time_bcd   = r_time_bcd;
    assign fix_valid  = r_fix_valid;
    assign frame_done = r_frame_done;
    assign cksum_ok   = r_cksum_ok;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_nmea_gll_parser.sv
// Directed bench for nmea_gll_parser: expected sentence results are queued as bytes are
// sent and compared when frame_done is seen.
module tb_nmea_gll_parser;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  lat_deg, lat_min, lon_deg, lon_min;
    logic        lat_south, lon_west, fix_valid, frame_done, cksum_ok, frame_err;
    logic [23:0] time_bcd;

    nmea_gll_parser dut (
        .Clk(Clk), .Reset(Reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .lat_deg(lat_deg), .lat_min(lat_min), .lat_south(lat_south),
        .lon_deg(lon_deg), .lon_min(lon_min), .lon_west(lon_west),
        .time_bcd(time_bcd), .fix_valid(fix_valid), .frame_done(frame_done),
        .cksum_ok(cksum_ok), .frame_err(frame_err)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic        ck;
        logic        fv;
        logic [7:0]  ld, lm;
        logic        ls;
        logic [7:0]  od, om;
        logic        ow;
        logic [23:0] t;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   vectors = 0, miscompares = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset && frame_done === 1'b1) begin
            done_cnt++;
            chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("cksum_ok",  32'(cksum_ok),  32'(e.ck));
                chk("fix_valid", 32'(fix_valid), 32'(e.fv));
                chk("lat_deg",   32'(lat_deg),   32'(e.ld));
                chk("lat_min",   32'(lat_min),   32'(e.lm));
                chk("lat_south", 32'(lat_south), 32'(e.ls));
                chk("lon_deg",   32'(lon_deg),   32'(e.od));
                chk("lon_min",   32'(lon_min),   32'(e.om));
                chk("lon_west",  32'(lon_west),  32'(e.ow));
                chk("time_bcd",  32'(time_bcd),  32'(e.t));
            end
        end
        if (!Reset && frame_err === 1'b1) err_cnt++;
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'b0, n};
        else           return 8'h37 + {4'b0, n};
    endfunction

    function automatic logic [7:0] xor_of(input string s);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < s.len(); i++) x ^= s[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge Clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_sentence(input string body, input logic [7:0] flip);
        logic [7:0] ck;
        ck = xor_of(body) ^ flip;
        send_str({"$", body, "*"});
        send_byte(hexc(ck[7:4]));
        send_byte(hexc(ck[3:0]));
    endtask

    task automatic expect_load(input logic [7:0] ld, lm, input logic ls,
                               input logic [7:0] od, om, input logic ow, input logic [23:0] t);
        held = '{ck: 1'b1, fv: 1'b1, ld: ld, lm: lm, ls: ls, od: od, om: om, ow: ow, t: t};
        sb_q.push_back(held);
    endtask

    task automatic expect_hold(input logic ck);
        exp_t e;
        e    = held;
        e.ck = ck;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge Clk);
        #1;
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lat_deg"},  32'(lat_deg),  32'd0);
        chk({tag, "_lat_min"},  32'(lat_min),  32'd0);
        chk({tag, "_lat_south"},32'(lat_south),32'd0);
        chk({tag, "_lon_deg"},  32'(lon_deg),  32'd0);
        chk({tag, "_lon_min"},  32'(lon_min),  32'd0);
        chk({tag, "_lon_west"}, 32'(lon_west), 32'd0);
        chk({tag, "_time"},     32'(time_bcd), 32'd0);
        chk({tag, "_fix_valid"},32'(fix_valid),32'd0);
        chk({tag, "_done"},     32'(frame_done),32'd0);
        chk({tag, "_cksum_ok"}, 32'(cksum_ok), 32'd0);
        chk({tag, "_err"},      32'(frame_err),32'd0);
    endtask

    initial begin
        int d0, e0, first;
        Reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        held     = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk_zero("reset");

        expect_load(8'd37, 8'd23, 1'b0, 8'd21, 8'd58, 1'b1, 24'h161229);
        send_sentence("GPGLL,3723.2445,N,2158.3438,W,161229.487,A,A", 8'h00);
        drain("s1_drain");

        expect_hold(1'b0);
        send_sentence("GPGLL,3723.2445,N,2158.3438,W,161229.487,A,A", 8'h01);
        drain("badck_drain");

        expect_hold(1'b1);
        send_str("$GPGLL*50");
        drain("empty_drain");

        expect_hold(1'b1);
        send_sentence("GPGLL,4000.0000,S,00100.0000,E,120000,V,A", 8'h00);
        drain("statv_drain");

        expect_load(8'd1, 8'd2, 1'b1, 8'd122, 8'd2, 1'b1, 24'h235959);
        send_sentence("GPGLL,0102.0000,S,12202.2470,W,235959.00,A,A", 8'h00);
        drain("lon5_drain");

        expect_load(8'd255, 8'd99, 1'b0, 8'd0, 8'd0, 1'b0, 24'h000000);
        send_sentence("GPGLL,99999.0,N,0000.0,E,000000,A,A", 8'h00);
        drain("sat_drain");

        d0 = done_cnt;
        send_str("$GP");
        send_byte("R");
        chk("rmc_err", 32'(frame_err), 32'd1);
        send_str("MC,1,2");
        drain("rmc_drain");
        chk("rmc_no_done", 32'(done_cnt - d0), 32'd0);

        d0 = done_cnt;
        send_str("$GPGLL,37");
        expect_load(8'd45, 8'd12, 1'b0, 8'd93, 8'd30, 1'b0, 24'h083015);
        send_sentence("GPGLL,4512.0000,N,09330.5000,E,083015,A,A", 8'h00);
        drain("restart_drain");
        chk("restart_one_done", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        e0 = err_cnt;
        first = 0;
        send_str("$GPGLL");
        for (int i = 7; i <= 96; i++) begin
            send_byte("1");
            if (frame_err === 1'b1 && first == 0) first = i;
        end
        drain("ovl_drain");
        chk("ovl_err_byte", 32'(first), 32'd83);
        chk("ovl_err_count", 32'(err_cnt - e0), 32'd1);
        chk("ovl_no_done", 32'(done_cnt - d0), 32'd0);

        send_str("$GPGLL,12");
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk_zero("midrst");
        held = '0;
        expect_load(8'd12, 8'd34, 1'b1, 8'd56, 8'd7, 1'b0, 24'h010203);
        send_sentence("GPGLL,1234.5,S,5607.8,E,010203.0,A,A", 8'h00);
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
